// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised rx, start bit validated at mid-bit, data sampled mid-bit LSB first.
// valid/frame_err strobe the cycle after the stop-bit sample; no backpressure, so data must be taken within one frame.
module uart_rx #(
  parameter int CLKS_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        sync1;
  logic        rxs;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx;
      rxs       <= sync1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= 16'd0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 16'd0;
            // A start bit that is already high again at mid-bit is line noise.
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= 16'd0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= 3'd0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= 16'd0;
            // Leaving mid-stop-bit lets a directly following start edge be caught.
            if (rxs) begin
              data  <= shreg;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) begin
            state <= IDLE;
            cnt   <= 16'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one task per scenario, strobes collected by a negedge monitor.
module tb_uart_rx;

  localparam int CPB = 50;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int       cyc = 0;
  int       valid_cnt = 0;
  int       ferr_cnt = 0;
  int       both_cnt = 0;
  int       valid_cyc = 0;
  logic     busy_at_valid = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(data);
      valid_cyc = cyc;
      busy_at_valid = busy;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(1'b1, CPB);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_idle;
    int vb, fb, busy_hi;
    vb = valid_cnt; fb = ferr_cnt; busy_hi = 0;
    rx = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hi++;
    end
    checks++; if (valid_cnt - vb !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses want 0", valid_cnt - vb); end
    checks++; if (ferr_cnt - fb !== 0) begin errors++; $display("FAIL idle_ferr: got %0d pulses want 0", ferr_cnt - fb); end
    checks++; if (busy_hi !== 0) begin errors++; $display("FAIL idle_busy: busy high %0d cycles want 0", busy_hi); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL idle_data: got %h want 00", data); end
  endtask

  task automatic test_single_byte;
    int vb, t_start;
    vb = valid_cnt;
    t_start = cyc;
    send_frame(8'h61);
    repeat (10) @(negedge clk);
    // rx low before edge +1, rxs low after edge +2 (t0), valid after edge t0+476.
    checks++; if (valid_cnt - vb !== 1) begin errors++; $display("FAIL single_count: got %0d pulses want 1", valid_cnt - vb); end
    checks++; if (data !== 8'h61) begin errors++; $display("FAIL single_data: got %h want 61", data); end
    checks++; if (valid_cyc - t_start !== 478) begin errors++; $display("FAIL single_latency: got %0d want 478", valid_cyc - t_start); end
    checks++; if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL single_busy_at_valid: got %b want 0", busy_at_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int vb, fb, qb;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'hA5;
    vb = valid_cnt; fb = ferr_cnt; qb = got_q.size();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i]);
    repeat (20) @(negedge clk);
    checks++; if (valid_cnt - vb !== 3) begin errors++; $display("FAIL b2b_count: got %0d pulses want 3", valid_cnt - vb); end
    checks++; if (ferr_cnt - fb !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d pulses want 0", ferr_cnt - fb); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_q.size() <= qb + i) begin
        errors++; $display("FAIL b2b_byte%0d: missing, want %h", i, exp_b[i]);
      end else if (got_q[qb + i] !== exp_b[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[qb + i], exp_b[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int vb, fb;
    vb = valid_cnt; fb = ferr_cnt;
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 100);
    checks++; if (valid_cnt - vb !== 0) begin errors++; $display("FAIL glitch_valid: got %0d pulses want 0", valid_cnt - vb); end
    checks++; if (ferr_cnt - fb !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - fb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h want a5", data); end
  endtask

  task automatic test_frame_err;
    int vb, fb;
    logic [7:0] b;
    vb = valid_cnt; fb = ferr_cnt;
    b = 8'h55;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(1'b0, 200);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b want 1", busy); end
    drive_bit(1'b1, 2 * CPB);
    checks++; if (ferr_cnt - fb !== 1) begin errors++; $display("FAIL ferr_count: got %0d pulses want 1", ferr_cnt - fb); end
    checks++; if (valid_cnt - vb !== 0) begin errors++; $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - vb); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_held: got %h want a5", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after: got %b want 0", busy); end
    vb = valid_cnt;
    send_frame(8'h3C);
    repeat (10) @(negedge clk);
    checks++; if (valid_cnt - vb !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d pulses want 1", valid_cnt - vb); end
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_next_data: got %h want 3c", data); end
  endtask

  task automatic test_reset_mid_frame;
    int vb, fb;
    logic [7:0] b;
    vb = valid_cnt; fb = ferr_cnt;
    b = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(b[i], CPB);
    drive_bit(b[4], CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data); end
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h12);
    repeat (10) @(negedge clk);
    checks++; if (valid_cnt - vb !== 1) begin errors++; $display("FAIL rstmid_count: got %0d pulses want 1", valid_cnt - vb); end
    checks++; if (ferr_cnt - fb !== 0) begin errors++; $display("FAIL rstmid_ferr: got %0d pulses want 0", ferr_cnt - fb); end
    checks++; if (data !== 8'h12) begin errors++; $display("FAIL rstmid_data_new: got %h want 12", data); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_idle();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
